// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: memop encodings and sequencer states.
package dmem_pkg;

  localparam logic [2:0] MEMOP_LB  = 3'b000;
  localparam logic [2:0] MEMOP_LH  = 3'b001;
  localparam logic [2:0] MEMOP_LW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_LD_RD  = 3'd1,
    ARB_LD_RSP = 3'd2,
    ARB_ST_RD  = 3'd3,
    ARB_ST_WR  = 3'd4
  } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side bundles for the single-clock data memory arbiter.
interface dmem_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [2:0]        memop;
  logic              we;
  logic              done;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, addr, wdata, memop, we, input ready, done, rdata);
  modport slave  (input valid, addr, wdata, memop, we, output ready, done, rdata);
endinterface

interface dmem_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] datain;
  logic [2:0]        memop;
  logic              we;
  logic              rd_en;
  logic              wr_en;
  logic [DATA_W-1:0] dataout;

  modport master (output addr, datain, memop, we, rd_en, wr_en, input dataout);
  modport slave  (input addr, datain, memop, we, rd_en, wr_en, output dataout);
endinterface

// File: rtl/dmem_arbiter_arb2.sv
// Two-way grant logic. DMEM_ARB_RR_EN selects round-robin; otherwise port 0 has fixed priority.
module arb2 (
`ifdef DMEM_ARB_RR_EN
  input  logic       clk,
  input  logic       reset,
`endif
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

`ifdef DMEM_ARB_RR_EN
  // last_gnt = 1 means port 1 won last; reset to 1 so port 0 wins the first tie.
  logic last_gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (accept) begin
      last_gnt <= gnt[1];
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      if (req == 2'b11) begin
        gnt = last_gnt ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end
`else
  always_comb begin
    gnt = 2'b00;
    if (accept) begin
      gnt[0] = req[0];
      gnt[1] = req[1] & ~req[0];
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the single-clock data memory.
// Arbitration mode set by DMEM_ARB_RR_EN (round-robin when defined, fixed priority otherwise).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  dmem_req_if.slave  m0,
  dmem_req_if.slave  m1,
  dmem_mem_if.master mem,
  output logic       busy
);

  localparam logic [2:0] S_IDLE   = ARB_IDLE;
  localparam logic [2:0] S_LD_RD  = ARB_LD_RD;
  localparam logic [2:0] S_LD_RSP = ARB_LD_RSP;
  localparam logic [2:0] S_ST_RD  = ARB_ST_RD;
  localparam logic [2:0] S_ST_WR  = ARB_ST_WR;

  logic [2:0]        state;
  logic              port_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        memop_q;
  logic              we_q;

  logic              active;
  logic              accept;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [2:0]        sel_memop;
  logic              sel_we;
  logic              done_any;
  logic              rsp_ld;

  // Every handshake and strobe is gated while reset is high so a reset cycle is silent.
  assign active = ~reset;
  assign req    = {m1.valid, m0.valid};
  assign accept = active && (state == S_IDLE) && (req != 2'b00);

  arb2 u_arb2 (
`ifdef DMEM_ARB_RR_EN
    .clk    (clk),
    .reset  (reset),
`endif
    .req    (req),
    .accept (accept),
    .gnt    (gnt)
  );

  assign m0.ready = gnt[0];
  assign m1.ready = gnt[1];

  always_comb begin
    sel_addr  = gnt[1] ? m1.addr  : m0.addr;
    sel_wdata = gnt[1] ? m1.wdata : m0.wdata;
    sel_memop = gnt[1] ? m1.memop : m0.memop;
    sel_we    = gnt[1] ? m1.we    : m0.we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      port_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      memop_q <= '0;
      we_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            port_q  <= gnt[1];
            addr_q  <= sel_addr;
            data_q  <= sel_wdata;
            memop_q <= sel_memop;
            we_q    <= sel_we;
            state   <= sel_we ? S_ST_RD : S_LD_RD;
          end
        end
        S_LD_RD:  state <= S_LD_RSP;
        S_LD_RSP: state <= S_IDLE;
        S_ST_RD:  state <= S_ST_WR;
        S_ST_WR:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Memory side: latched request held through IDLE, strobes decoded from state.
  assign mem.addr   = addr_q;
  assign mem.datain = data_q;
  assign mem.memop  = memop_q;
  assign mem.we     = we_q;
  assign mem.rd_en  = active && ((state == S_LD_RD) || (state == S_ST_RD));
  assign mem.wr_en  = active && (state == S_ST_WR);

  assign done_any = active && ((state == S_LD_RSP) || (state == S_ST_WR));
  assign rsp_ld   = active && (state == S_LD_RSP);

  assign m0.done  = done_any && !port_q;
  assign m1.done  = done_any &&  port_q;
  assign m0.rdata = (rsp_ld && !port_q) ? mem.dataout : '0;
  assign m1.rdata = (rsp_ld &&  port_q) ? mem.dataout : '0;

  assign busy = active && (state != S_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected completions, a monitor checks them.
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy;
  always #5 clk = ~clk;

  dmem_req_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  dmem_req_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  dmem_mem_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .mem   (mem_if),
    .busy  (busy)
  );

  typedef struct {
    int          port;
    bit          is_ld;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] datain;
    logic [2:0]  memop;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory model: one registered read per rd_en; 0x100 holds DEADBEEF, others C0DE_<addr[15:0]>.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_if.rd_en) mem_if.dataout <= mem_word(mem_if.addr);
  end

  // Monitor: timing of strobes/done relative to the last accept, plus scoreboard compare on done.
  int   acc_cyc = -100;
  bit   acc_st = 1'b0;
  logic exp_rd, exp_wr, exp_done;
  exp_t e;

  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        chk("rst_quiet", {28'b0, mem_if.rd_en, mem_if.wr_en, m0_if.done | m1_if.done,
                          m0_if.ready | m1_if.ready}, 32'h0);
        acc_cyc = -100;
      end else begin
        exp_rd   = (cyc == acc_cyc + 1);
        exp_wr   = acc_st && (cyc == acc_cyc + 2);
        exp_done = (cyc == acc_cyc + 2);
        chk("rd_en", {31'b0, mem_if.rd_en}, {31'b0, exp_rd});
        chk("wr_en", {31'b0, mem_if.wr_en}, {31'b0, exp_wr});
        if (m0_if.done || m1_if.done) begin
          chk("done_onehot", {31'b0, m0_if.done & m1_if.done}, 32'h0);
          chk("done_time", cyc, acc_cyc + 2);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
          end else begin
            e = sb.pop_front();
            chk("done_port", {31'b0, m1_if.done}, e.port);
            chk("mem_addr", mem_if.addr, e.addr);
            chk("mem_memop", {29'b0, mem_if.memop}, {29'b0, e.memop});
            chk("mem_we", {31'b0, mem_if.we}, {31'b0, !e.is_ld});
            if (e.is_ld) chk("rdata", m1_if.done ? m1_if.rdata : m0_if.rdata, e.rdata);
            else         chk("mem_datain", mem_if.datain, e.datain);
          end
        end else if (exp_done) begin
          checks++;
          failures++;
          $display("FAIL done_missing: got no done at cycle %0d expected done", cyc);
        end
        if (m0_if.ready || m1_if.ready) begin
          chk("ready_onehot", {31'b0, m0_if.ready & m1_if.ready}, 32'h0);
          chk("accept_gap", {31'b0, cyc >= acc_cyc + 3}, 32'h1);
          acc_cyc = cyc;
          acc_st  = m1_if.ready ? m1_if.we : m0_if.we;
        end
      end
    end
  end

  task automatic drive(int p, logic [31:0] a, logic [31:0] wd, logic [2:0] op, logic we);
    if (p == 0) begin
      m0_if.addr = a; m0_if.wdata = wd; m0_if.memop = op; m0_if.we = we; m0_if.valid = 1'b1;
    end else begin
      m1_if.addr = a; m1_if.wdata = wd; m1_if.memop = op; m1_if.we = we; m1_if.valid = 1'b1;
    end
  endtask

  task automatic drop(int p);
    if (p == 0) m0_if.valid = 1'b0;
    else        m1_if.valid = 1'b0;
  endtask

  task automatic wait_ready(int p, output int t);
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((p == 0) ? m0_if.ready : m1_if.ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got no ready on port %0d within 20 cycles, expected ready", p);
    end
    @(posedge clk);
    #1;
  endtask

  int t0, t1, n;

  initial begin
    m0_if.valid = 0; m0_if.addr = 0; m0_if.wdata = 0; m0_if.memop = 0; m0_if.we = 0;
    m1_if.valid = 0; m1_if.addr = 0; m1_if.wdata = 0; m1_if.memop = 0; m1_if.we = 0;
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_mem_addr", mem_if.addr, 32'h0);
    chk("rst_mem_datain", mem_if.datain, 32'h0);
    chk("rst_mem_memop", {29'b0, mem_if.memop}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_if.we}, 32'h0);
    chk("rst_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
    @(posedge clk);
    #1;

    // Port 0 word load from 0x100.
    sb.push_back('{0, 1'b1, 32'hDEADBEEF, 32'h100, 32'h0, MEMOP_LW});
    drive(0, 32'h100, 32'h0, MEMOP_LW, 1'b0);
    wait_ready(0, t0);
    drop(0);
    repeat (3) @(posedge clk);
    #1;

    // Port 1 byte store of 0x5A at 0x203.
    sb.push_back('{1, 1'b0, 32'h0, 32'h203, 32'h5A, MEMOP_LB});
    drive(1, 32'h203, 32'h5A, MEMOP_LB, 1'b1);
    wait_ready(1, t0);
    drop(1);
    repeat (3) @(posedge clk);
    #1;

    // Tie: both ports hold loads continuously for four accepts.
`ifdef DMEM_ARB_RR_EN
    sb.push_back('{0, 1'b1, 32'hC0DE0300, 32'h300, 32'h0, MEMOP_LW});
    sb.push_back('{1, 1'b1, 32'hC0DE0400, 32'h400, 32'h0, MEMOP_LW});
    sb.push_back('{0, 1'b1, 32'hC0DE0300, 32'h300, 32'h0, MEMOP_LW});
    sb.push_back('{1, 1'b1, 32'hC0DE0400, 32'h400, 32'h0, MEMOP_LW});
`else
    repeat (4) sb.push_back('{0, 1'b1, 32'hC0DE0300, 32'h300, 32'h0, MEMOP_LW});
`endif
    drive(0, 32'h300, 32'h0, MEMOP_LW, 1'b0);
    drive(1, 32'h400, 32'h0, MEMOP_LW, 1'b0);
    n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (m0_if.ready || m1_if.ready) n++;
    end
    chk("tie_accepts", n, 4);
    @(posedge clk);
    #1;
    drop(0);
    drop(1);
    repeat (4) @(posedge clk);
    #1;

    // Port 1 arrives while a port 0 load is in flight; accepted three cycles after port 0.
    sb.push_back('{0, 1'b1, 32'hDEADBEEF, 32'h100, 32'h0, MEMOP_LW});
    sb.push_back('{1, 1'b0, 32'h0, 32'h204, 32'h1234ABCD, MEMOP_LW});
    drive(0, 32'h100, 32'h0, MEMOP_LW, 1'b0);
    wait_ready(0, t0);
    drop(0);
    drive(1, 32'h204, 32'h1234ABCD, MEMOP_LW, 1'b1);
    wait_ready(1, t1);
    chk("stall_accept", t1, t0 + 3);
    drop(1);
    repeat (3) @(posedge clk);
    #1;

    // Reset while the store sits in ST_RD: no write, no done.
    drive(0, 32'h600, 32'hAA, MEMOP_LW, 1'b1);
    wait_ready(0, t0);
    drop(0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_wr_en", {31'b0, mem_if.wr_en}, 32'h0);
    @(posedge clk);
    #1;

    // Undefined memop 111 load still completes normally.
    sb.push_back('{0, 1'b1, 32'hC0DE0700, 32'h700, 32'h0, 3'b111});
    drive(0, 32'h700, 32'h0, 3'b111, 1'b0);
    wait_ready(0, t0);
    drop(0);
    repeat (4) @(posedge clk);
    #1;

    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the single-clock data memory. It shares the memory between the CPU data port (port 0) and a debug/loader port (port 1). It accepts one request at a time through a valid/ready handshake and sequences the memory read and write strobes: a load takes one read cycle, and a store takes a read-then-write pair so the memory can merge byte lanes. It sits between `rv32is`/debug logic and `dmem`, replacing the separate `rdclk`/`wrclk` drive with single-clock enables.

## Interface
Parameters:
- `ADDR_W`, 32, address width for both ports and memory.
- `DATA_W`, 32, data width.

Ports (clk, reset synchronous active-high):
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `m0_valid` in 1: port 0 request present.
- `m0_ready` out 1: port 0 request accepted this cycle.
- `m0_addr` in `ADDR_W`: byte address.
- `m0_wdata` in `DATA_W`: store data, low-aligned.
- `m0_memop` in 3: access size and sign (000 b, 001 h, 010 w, 100 bu, 101 hu).
- `m0_we` in 1: 1 = store, 0 = load.
- `m0_done` out 1: one-cycle completion pulse.
- `m0_rdata` out `DATA_W`: load result; valid only while `m0_done` is high and the access is a load.
- `m1_*`: identical set for port 1.
- `mem_addr` out `ADDR_W`: latched address.
- `mem_datain` out `DATA_W`: latched store data.
- `mem_memop` out 3: latched memop.
- `mem_we` out 1: store in progress (level).
- `mem_rd_en` out 1: read strobe. The memory registers its word at the end of this cycle.
- `mem_wr_en` out 1: write strobe.
- `mem_dataout` in `DATA_W`: memory read data, available the cycle after `mem_rd_en`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- States: IDLE, LD_RD, LD_RSP, ST_RD, ST_WR.
- **IDLE**
  - If any valid, select the winner, assert the winner's `mX_ready` for exactly one cycle, and latch addr, wdata, memop, we and the port id.
  - Next state is LD_RD if `we=0`, otherwise ST_RD.
  - `mX_ready` is asserted only in IDLE.
- **LD_RD:** `mem_rd_en=1`, `mem_we=0`. Next state LD_RSP.
- **LD_RSP:** `mX_done=1` for the latched port, and `mX_rdata` is driven combinationally from `mem_dataout`. Next state IDLE.
- **ST_RD:** `mem_we=1`, `mem_rd_en=1`, which captures the old word for the lane merge. Next state ST_WR.
- **ST_WR:** `mem_we=1`, `mem_wr_en=1`, `mX_done=1`. Next state IDLE.
- Memory-side outputs hold their latched values from acceptance until return to IDLE. In IDLE they hold their last values, and all strobes are 0.
- Undefined memops (011, 110, 111) are sequenced normally. Byte masking and extension are left to the memory, and `done` still pulses.
- The non-granted requester keeps valid high and its request stable. It is served in the next IDLE cycle.
- Requesters must hold a request stable while `valid && !ready`. Deasserting valid before ready is permitted and drops the request.
- Port 1 is a pure peer: there is no preemption, and an in-flight access always completes.

## Timing
- Load accepted in cycle T (ready high): strobe at T+1, `done` and `rdata` at T+2, next accept no earlier than T+3.
- Store accepted in cycle T: read strobe at T+1, write strobe and `done` at T+2, next accept no earlier than T+3.
- Sustained throughput is one access per 3 cycles.
- Reset values:
  - State IDLE; all ready, done and strobe outputs 0.
  - `mem_addr`, `mem_datain`, `mem_memop`, `mem_rdata` paths 0; `busy` 0.
  - Round-robin pointer set so that port 0 wins first.
- Reset mid-operation: the in-flight access is dropped, no `done` is issued, and no strobe is asserted in the reset cycle or the cycle after.
- Simultaneous valid on both ports in IDLE: resolved per Configuration. Exactly one ready is high.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer is updated on every acceptance.
  - On a tie, the port that was not granted last wins.
- `DMEM_ARB_RR_EN` undefined: fixed priority, port 0 always wins a tie. No pointer flop exists.

## Structure
- Shared package `dmem_pkg`:
  - memop constants `MEMOP_LB`, `MEMOP_LH`, `MEMOP_LW`, `MEMOP_LBU`, `MEMOP_LHU`;
  - state enum `dmem_arb_state_t`.
- One sub-module, `arb2`: 2-way grant logic (fixed or round-robin per the macro) with inputs `req[1:0]`, `accept` and output `gnt[1:0]` one-hot.

## Test plan
- **Port 0 word load:** load word at `0x100`, memory returns `0xDEADBEEF` → `m0_ready` at T, `mem_rd_en` at T+1, `m0_done=1` with `m0_rdata=0xDEADBEEF` at T+2.
- **Port 1 byte store:** sb `0x5A` at `0x203` → `mem_rd_en`+`mem_we` at T+1, `mem_wr_en` at T+2 with `mem_addr=0x203`, `mem_memop=000`, `mem_datain=0x5A`, `m1_done` at T+2.
- **Tie behaviour:** both ports valid continuously for 4 accesses → with `DMEM_ARB_RR_EN` the grants are 0,1,0,1; without it the grants are 0,0,0,0 and port 1 is starved.
- **Back-to-back stalled request:** port 1 presents a request while a port 0 access is in flight → port 1 is accepted at T+3 with its request unchanged.
- **Reset mid-store:** assert reset during ST_RD → no `mem_wr_en`, no `done`, `busy=0` after reset, and the next request is served normally.
- **Undefined memop:** memop 111 load → still completes at T+2 with `m0_rdata` equal to `mem_dataout`.
